audio_adc_rx: RTL and testbench
===============================

Name: audio_adc_rx

Overview:
- Receive-side counterpart of the codec DAC serializer.
- Deserializes the codec ADC stream (AUD_ADCDAT, framed by AUD_BCLK and AUD_ADCLRCK) into parallel stereo sample pairs in the iCLK domain.
- Presents each complete frame on a valid/ready handshake.
- Sits between the audio codec pins and downstream DSP or loopback logic; the codec is configured over I2C by the existing config block.

Parameters:
- DATA_WIDTH, 16, bits per channel word captured; must be 8..32.
- I2S_MODE, 1, 1 = I2S (MSB one BCLK after the LRCK edge), 0 = left-justified (MSB on the first BCLK after the LRCK edge).

Ports:
- iCLK  in  1  system clock, 50 MHz; must be at least 4x BCLK.
- iRST  in  1  synchronous, active-high reset.
- iAUD_BCLK  in  1  serial bit clock, asynchronous to iCLK.
- iAUD_ADCLRCK  in  1  frame clock; 0 = left, 1 = right; asynchronous.
- iAUD_ADCDAT  in  1  serial data, MSB first; asynchronous.
- oLEFT  out  DATA_WIDTH  left sample, two's complement.
- oRIGHT  out  DATA_WIDTH  right sample, two's complement.
- oVALID  out  1  frame available.
- iREADY  in  1  consumer accepts the frame.
- oOVERFLOW  out  1  sticky: a frame was dropped because the output was still held.
- oFRAME_ERR  out  1  sticky: a word was truncated by an early LRCK edge.
- iCLR_FLAGS  in  1  clears both sticky flags.

Behaviour:
- Input synchronization and edge detection
  - BCLK, LRCK and DAT each pass through a 2-flop synchronizer.
  - A third register on BCLK gives bclk_rise = sync & ~prev.
  - LRCK and DAT are sampled only on bclk_rise cycles.
  - lrck_edge = sampled LRCK != LRCK sampled at the previous bclk_rise.
- State machine, advanced only on bclk_rise:
  - ALIGN: wait for LRCK high->low. Then go to LEFT, bit_cnt=0, set skip=I2S_MODE.
  - LEFT / RIGHT, on each bclk_rise:
    - If skip=1: clear skip and discard DAT.
    - Else if bit_cnt<DATA_WIDTH: shift DAT into shreg LSB, bit_cnt++.
    - Else: extra bits beyond DATA_WIDTH are ignored.
  - LRCK low->high in LEFT:
    - If bit_cnt==DATA_WIDTH: latch shreg into left_hold, go to RIGHT.
    - Else: set oFRAME_ERR and go to RIGHT; the frame is marked bad.
    - The bit on this edge is handled per skip rules (I2S_MODE=0: it is the right MSB).
  - LRCK high->low in RIGHT:
    - If bit_cnt==DATA_WIDTH and the frame is not bad: commit the frame.
    - Else: set oFRAME_ERR and drop the frame.
    - Then go to LEFT with fresh counters.
  - A right word completes at bit_cnt==DATA_WIDTH, but commit happens on the next LRCK edge. Commit latency: oVALID rises 1 iCLK after the synchronized bclk_rise carrying that LRCK edge, i.e. 4 iCLK after the pin edge.
- Commit
  - If oVALID==0, or (oVALID & iREADY) in the same cycle: oLEFT<=left_hold, oRIGHT<=shreg, oVALID<=1.
  - If oVALID & ~iREADY: the frame is dropped, outputs are unchanged, oOVERFLOW<=1.
- Handshake
  - oVALID falls the cycle after oVALID & iREADY, unless a commit occurs in that same cycle, in which case it stays 1 with new data.
  - oLEFT and oRIGHT are stable while oVALID=1.
- Flags
  - iCLR_FLAGS clears both flags.
  - If a set event coincides with iCLR_FLAGS, the set wins.
- Reset
  - All outputs go to 0; the state machine goes to ALIGN; counters, shreg, holds and synchronizers are cleared.
  - Reset mid-word discards the partial frame. The first frame after reset is the first complete left+right pair following an LRCK falling edge.
- Loss of BCLK: the state is held indefinitely; there is no timeout.

Decomposition:
- Shared package audio_pkg holds:
  - the state enum {ALIGN, LEFT, RIGHT};
  - the default DATA_WIDTH constant;
  - the mode constants I2S / LJ.
- Sub-module audio_sync_edge: 2-flop synchronizer plus rise/fall detect, instantiated for BCLK and LRCK; DAT uses the synchronizer only.

Test Plan:
1. I2S, 16 bit, BCLK=iCLK/16, frames L=16'hA55A, R=16'h1234, iREADY=1 -> oVALID 1-cycle pulse with oLEFT=A55A, oRIGHT=1234; no flags.
2. Stream starts mid-right-word after reset -> no oVALID until the first LRCK fall; then the first full frame L=0x8001, R=0x7FFE is reported exactly.
3. iREADY=0 for 3 frames (0x0001/0x0002, 0x0003/0x0004, 0x0005/0x0006) -> outputs hold 0001/0002 and oOVERFLOW=1. With iREADY=1 afterwards the next frame is delivered; iCLR_FLAGS clears oOVERFLOW.
4. Left word truncated to 10 BCLKs -> that frame is dropped, oFRAME_ERR=1, and the following good frame 0xFFFF/0x0000 is delivered.
5. I2S_MODE=0, DATA_WIDTH=24, 32 BCLKs per channel, L=24'h800000, R=24'h7FFFFF -> correct capture; the 8 trailing bits are ignored.
6. iRST asserted mid-left-word -> outputs 0 next cycle; the state machine realigns and the next complete frame is correct.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the codec audio receive path.
package audio_pkg;

   typedef enum logic [1:0] {
      ALIGN,
      LEFT,
      RIGHT
   } rx_state_t;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam bit MODE_I2S           = 1'b1;
   localparam bit MODE_LJ            = 1'b0;

endpackage

// File: rtl/audio_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall detect
// taken from a third register stage.
module audio_sync_edge (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [2:0] pipe_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         pipe_reg <= '0;
      end else begin
         pipe_reg <= {pipe_reg[1:0], din};
      end
   end

   assign sync_out = pipe_reg[1];
   assign rise     = pipe_reg[1] & ~pipe_reg[2];
   assign fall     = ~pipe_reg[1] & pipe_reg[2];

endmodule

// File: rtl/audio_adc_rx.sv
// Codec ADC receiver: deserializes I2S / left-justified stereo frames into
// parallel sample pairs presented on a valid/ready handshake.
module audio_adc_rx
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter bit I2S_MODE   = MODE_I2S
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iAUD_BCLK,
   input  logic                  iAUD_ADCLRCK,
   input  logic                  iAUD_ADCDAT,
   output logic [DATA_WIDTH-1:0] oLEFT,
   output logic [DATA_WIDTH-1:0] oRIGHT,
   output logic                  oVALID,
   input  logic                  iREADY,
   output logic                  oOVERFLOW,
   output logic                  oFRAME_ERR,
   input  logic                  iCLR_FLAGS
);

   localparam int            CW       = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

   // Index 0 is BCLK, index 1 is LRCK.
   logic [1:0] pin_vec, sync_vec, rise_vec, fall_vec;
   logic       unused_edges;
   genvar      gi;

   assign pin_vec = {iAUD_ADCLRCK, iAUD_BCLK};

   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         audio_sync_edge u_sync (
            .clk      (iCLK),
            .srst     (iRST),
            .din      (pin_vec[gi]),
            .sync_out (sync_vec[gi]),
            .rise     (rise_vec[gi]),
            .fall     (fall_vec[gi])
         );
      end
   endgenerate

   assign unused_edges = ^{sync_vec[0], rise_vec[1], fall_vec};

   logic       bclk_rise, lrck_sync, lrck_edge;
   logic [1:0] dat_pipe_reg;

   assign bclk_rise = rise_vec[0];
   assign lrck_sync = sync_vec[1];

   rx_state_t             state_reg, state_next;
   logic [CW-1:0]         bit_cnt_reg, bit_cnt_next, cnt_cur;
   logic                  skip_reg, skip_next, skip_cur;
   logic                  bad_reg, bad_next;
   logic                  lrck_prev_reg;
   logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
   logic [DATA_WIDTH-1:0] left_hold_reg, left_hold_next;
   logic [DATA_WIDTH-1:0] right_hold_reg, right_hold_next;
   logic                  commit_reg, commit_next;
   logic                  start_word, frame_err_set;

   logic [DATA_WIDTH-1:0] left_out_reg, right_out_reg;
   logic                  valid_reg, overflow_reg, frame_err_reg;
   logic                  load, overflow_set;

   assign lrck_edge = lrck_sync != lrck_prev_reg;

   always_comb begin
      state_next      = state_reg;
      bit_cnt_next    = bit_cnt_reg;
      skip_next       = skip_reg;
      bad_next        = bad_reg;
      shreg_next      = shreg_reg;
      left_hold_next  = left_hold_reg;
      right_hold_next = right_hold_reg;
      commit_next     = 1'b0;
      frame_err_set   = 1'b0;
      start_word      = 1'b0;
      skip_cur        = skip_reg;
      cnt_cur         = bit_cnt_reg;

      if (bclk_rise) begin
         case (state_reg)
            ALIGN: begin
               if (lrck_edge && !lrck_sync) begin
                  state_next = LEFT;
                  bad_next   = 1'b0;
                  start_word = 1'b1;
               end
            end
            LEFT: begin
               if (lrck_edge && lrck_sync) begin
                  if (bit_cnt_reg == FULL_CNT) begin
                     left_hold_next = shreg_reg;
                  end else begin
                     frame_err_set = 1'b1;
                     bad_next      = 1'b1;
                  end
                  state_next = RIGHT;
                  start_word = 1'b1;
               end
            end
            RIGHT: begin
               if (lrck_edge && !lrck_sync) begin
                  if (bit_cnt_reg == FULL_CNT && !bad_reg) begin
                     commit_next     = 1'b1;
                     right_hold_next = shreg_reg;
                  end else begin
                     frame_err_set = 1'b1;
                  end
                  state_next = LEFT;
                  bad_next   = 1'b0;
                  start_word = 1'b1;
               end
            end
            default: state_next = ALIGN;
         endcase

         // The bit on an LRCK edge already belongs to the new word.
         if (start_word) begin
            skip_cur = I2S_MODE;
            cnt_cur  = '0;
         end
         if (state_next != ALIGN) begin
            skip_next    = 1'b0;
            bit_cnt_next = cnt_cur;
            if (!skip_cur && cnt_cur < FULL_CNT) begin
               shreg_next   = {shreg_reg[DATA_WIDTH-2:0], dat_pipe_reg[1]};
               bit_cnt_next = cnt_cur + CW'(1);
            end
         end
      end
   end

   assign load         = commit_reg & (~valid_reg | iREADY);
   assign overflow_set = commit_reg & valid_reg & ~iREADY;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         dat_pipe_reg   <= '0;
         state_reg      <= ALIGN;
         bit_cnt_reg    <= '0;
         skip_reg       <= 1'b0;
         bad_reg        <= 1'b0;
         lrck_prev_reg  <= 1'b0;
         shreg_reg      <= '0;
         left_hold_reg  <= '0;
         right_hold_reg <= '0;
         commit_reg     <= 1'b0;
         left_out_reg   <= '0;
         right_out_reg  <= '0;
         valid_reg      <= 1'b0;
         overflow_reg   <= 1'b0;
         frame_err_reg  <= 1'b0;
      end else begin
         dat_pipe_reg   <= {dat_pipe_reg[0], iAUD_ADCDAT};
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         skip_reg       <= skip_next;
         bad_reg        <= bad_next;
         shreg_reg      <= shreg_next;
         left_hold_reg  <= left_hold_next;
         right_hold_reg <= right_hold_next;
         commit_reg     <= commit_next;
         if (bclk_rise) begin
            lrck_prev_reg <= lrck_sync;
         end
         if (valid_reg && iREADY) begin
            valid_reg <= 1'b0;
         end
         if (load) begin
            left_out_reg  <= left_hold_reg;
            right_out_reg <= right_hold_reg;
            valid_reg     <= 1'b1;
         end
         // A set event in the same cycle as a clear request wins.
         overflow_reg  <= overflow_set | (overflow_reg & ~iCLR_FLAGS);
         frame_err_reg <= frame_err_set | (frame_err_reg & ~iCLR_FLAGS);
      end
   end

   assign oLEFT      = left_out_reg;
   assign oRIGHT     = right_out_reg;
   assign oVALID     = valid_reg;
   assign oOVERFLOW  = overflow_reg;
   assign oFRAME_ERR = frame_err_reg;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: an I2S/16-bit instance and an LJ/24-bit
// instance share one serial stream; each accepted frame is logged.
module tb_audio_adc_rx;

   localparam int T_CLK     = 20;
   localparam int BCLK_HALF = 8 * T_CLK;
   localparam int NB        = 32;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic        bclk = 1'b0;
   logic        lrck = 1'b1;
   logic        dat = 1'b0;
   logic        ready = 1'b1;
   logic        ready_lj = 1'b1;
   logic        clr = 1'b0;

   logic [15:0] left16, right16;
   logic        valid16, ovf16, ferr16;
   logic [23:0] left24, right24;
   logic        valid24, ovf24, ferr24;

   int          n_checks = 0;
   int          n_errors = 0;
   int          valid_cycles = 0;
   logic        valid16_q = 1'b0;
   time         rise_t = 0;
   time         pin_rise_t = 0;
   time         t_close = 0;
   logic [31:0] acc_l[$], acc_r[$], lj_l[$], lj_r[$];

   always #(T_CLK / 2) iCLK = ~iCLK;

   audio_adc_rx #(.DATA_WIDTH(16), .I2S_MODE(1'b1)) dut (
      .iCLK(iCLK), .iRST(iRST), .iAUD_BCLK(bclk), .iAUD_ADCLRCK(lrck),
      .iAUD_ADCDAT(dat), .oLEFT(left16), .oRIGHT(right16), .oVALID(valid16),
      .iREADY(ready), .oOVERFLOW(ovf16), .oFRAME_ERR(ferr16), .iCLR_FLAGS(clr)
   );

   audio_adc_rx #(.DATA_WIDTH(24), .I2S_MODE(1'b0)) dut_lj (
      .iCLK(iCLK), .iRST(iRST), .iAUD_BCLK(bclk), .iAUD_ADCLRCK(lrck),
      .iAUD_ADCDAT(dat), .oLEFT(left24), .oRIGHT(right24), .oVALID(valid24),
      .iREADY(ready_lj), .oOVERFLOW(ovf24), .oFRAME_ERR(ferr24), .iCLR_FLAGS(clr)
   );

   always @(negedge iCLK) begin
      if (valid16) valid_cycles++;
      if (valid16 && !valid16_q) rise_t = $time;
      valid16_q = valid16;
      if (valid16 && ready) begin
         acc_l.push_back(32'(left16));
         acc_r.push_back(32'(right16));
         $display("frame i2s16: left=%h right=%h", left16, right16);
      end
      if (valid24 && ready_lj) begin
         lj_l.push_back(32'(left24));
         lj_r.push_back(32'(right24));
         $display("frame lj24: left=%h right=%h", left24, right24);
      end
   end

   // sel: 0/1 = I2S left/right, 2/3 = LJ left/right; missing entries read as all ones.
   function automatic logic [31:0] got(input int sel, input int i);
      logic [31:0] v;
      v = 32'hFFFF_FFFF;
      case (sel)
         0: if (i < acc_l.size()) v = acc_l[i];
         1: if (i < acc_r.size()) v = acc_r[i];
         2: if (i < lj_l.size()) v = lj_l[i];
         default: if (i < lj_r.size()) v = lj_r[i];
      endcase
      return v;
   endfunction

   task automatic slot(input logic lr, input logic d);
      bclk = 1'b0; lrck = lr; dat = d;
      #(BCLK_HALF);
      bclk = 1'b1; pin_rise_t = $time;
      #(BCLK_HALF);
   endtask

   // Slot 0 is the BCLK after the LRCK edge; unused slots carry ones.
   task automatic send_channel(input logic lr, input logic [31:0] word, input int width,
                               input bit i2s, input int nbclk, input int first);
      for (int k = first; k < nbclk; k++) begin
         int  pos;
         logic d;
         pos = i2s ? k - 1 : k;
         d = (pos >= 0 && pos < width) ? word[width-1-pos] : 1'b1;
         slot(lr, d);
      end
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int width,
                             input bit i2s, input int nl, input int first);
      send_channel(1'b0, l, width, i2s, nl, first);
      send_channel(1'b1, r, width, i2s, NB, 0);
   endtask

   task automatic lead_in(input int nl, input int nr);
      for (int k = 0; k < nl; k++) slot(1'b0, k[0]);
      for (int k = 0; k < nr; k++) slot(1'b1, ~k[0]);
   endtask

   // One left-channel slot: supplies the LRCK fall that commits the last frame.
   task automatic close_frame();
      slot(1'b0, 1'b1);
      t_close = pin_rise_t;
      bclk = 1'b0;
      #(BCLK_HALF);
   endtask

   task automatic rst_dut();
      @(posedge iCLK); #1;
      iRST = 1'b1; ready = 1'b1; clr = 1'b0;
      repeat (2) @(posedge iCLK);
      #1 iRST = 1'b0;
      acc_l.delete(); acc_r.delete(); lj_l.delete(); lj_r.delete();
      valid_cycles = 0;
      #2;
   endtask

   task automatic test_reset();
      repeat (4) @(posedge iCLK);
      @(negedge iCLK);
      n_checks++; if (valid16 !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid16); end
      n_checks++; if (left16 !== 16'h0) begin n_errors++; $display("FAIL reset_left: got %h expected 0000", left16); end
      n_checks++; if (right16 !== 16'h0) begin n_errors++; $display("FAIL reset_right: got %h expected 0000", right16); end
      n_checks++; if ({ovf16, ferr16} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b expected 00", {ovf16, ferr16}); end
      n_checks++; if ({valid24, ovf24, ferr24} !== 3'b000) begin n_errors++; $display("FAIL reset_lj: got %b expected 000", {valid24, ovf24, ferr24}); end
   endtask

   task automatic test_basic();
      time d;
      rst_dut();
      lead_in(0, 4);
      send_frame(32'hA55A, 32'h1234, 16, 1'b1, NB, 0);
      close_frame();
      d = rise_t - t_close;
      n_checks++; if (acc_l.size() !== 1) begin n_errors++; $display("FAIL basic_count: got %0d expected 1", acc_l.size()); end
      n_checks++; if (got(0, 0) !== 32'hA55A) begin n_errors++; $display("FAIL basic_left: got %h expected 0000a55a", got(0, 0)); end
      n_checks++; if (got(1, 0) !== 32'h1234) begin n_errors++; $display("FAIL basic_right: got %h expected 00001234", got(1, 0)); end
      n_checks++; if (valid_cycles !== 1) begin n_errors++; $display("FAIL basic_pulse: got %0d valid cycles expected 1", valid_cycles); end
      n_checks++; if ({ovf16, ferr16} !== 2'b00) begin n_errors++; $display("FAIL basic_flags: got %b expected 00", {ovf16, ferr16}); end
      n_checks++; if (!(d >= 4 * T_CLK && d < 5 * T_CLK)) begin n_errors++; $display("FAIL basic_latency: got %0t expected 4 iCLK after pin edge", d); end
   endtask

   task automatic test_back_to_back();
      rst_dut();
      lead_in(0, 3);
      send_frame(32'h0102, 32'h0304, 16, 1'b1, NB, 0);
      send_frame(32'hFEDC, 32'hBA98, 16, 1'b1, NB, 0);
      close_frame();
      n_checks++; if (acc_l.size() !== 2) begin n_errors++; $display("FAIL b2b_count: got %0d expected 2", acc_l.size()); end
      n_checks++; if (got(0, 0) !== 32'h0102 || got(1, 0) !== 32'h0304) begin n_errors++; $display("FAIL b2b_first: got %h/%h expected 0102/0304", got(0, 0), got(1, 0)); end
      n_checks++; if (got(0, 1) !== 32'hFEDC || got(1, 1) !== 32'hBA98) begin n_errors++; $display("FAIL b2b_second: got %h/%h expected fedc/ba98", got(0, 1), got(1, 1)); end
      n_checks++; if (valid_cycles !== 2) begin n_errors++; $display("FAIL b2b_pulses: got %0d expected 2", valid_cycles); end
   endtask

   task automatic test_mid_start();
      rst_dut();
      lrck = 1'b0;
      lead_in(5, 11);
      n_checks++; if (valid_cycles !== 0) begin n_errors++; $display("FAIL midstart_early: got %0d valid cycles expected 0", valid_cycles); end
      send_frame(32'h8001, 32'h7FFE, 16, 1'b1, NB, 0);
      close_frame();
      n_checks++; if (acc_l.size() !== 1) begin n_errors++; $display("FAIL midstart_count: got %0d expected 1", acc_l.size()); end
      n_checks++; if (got(0, 0) !== 32'h8001) begin n_errors++; $display("FAIL midstart_left: got %h expected 00008001", got(0, 0)); end
      n_checks++; if (got(1, 0) !== 32'h7FFE) begin n_errors++; $display("FAIL midstart_right: got %h expected 00007ffe", got(1, 0)); end
      n_checks++; if (ferr16 !== 1'b0) begin n_errors++; $display("FAIL midstart_ferr: got %b expected 0", ferr16); end
   endtask

   task automatic test_overflow();
      rst_dut();
      ready = 1'b0;
      lead_in(0, 4);
      send_frame(32'h0001, 32'h0002, 16, 1'b1, NB, 0);
      send_frame(32'h0003, 32'h0004, 16, 1'b1, NB, 0);
      send_frame(32'h0005, 32'h0006, 16, 1'b1, NB, 0);
      close_frame();
      @(negedge iCLK);
      n_checks++; if (valid16 !== 1'b1) begin n_errors++; $display("FAIL ovf_valid_held: got %b expected 1", valid16); end
      n_checks++; if (left16 !== 16'h0001 || right16 !== 16'h0002) begin n_errors++; $display("FAIL ovf_hold: got %h/%h expected 0001/0002", left16, right16); end
      n_checks++; if (ovf16 !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b expected 1", ovf16); end
      n_checks++; if (acc_l.size() !== 0) begin n_errors++; $display("FAIL ovf_no_accept: got %0d expected 0", acc_l.size()); end
      @(posedge iCLK); #1 ready = 1'b1;
      repeat (3) @(negedge iCLK);
      n_checks++; if (acc_l.size() !== 1 || got(0, 0) !== 32'h0001) begin n_errors++; $display("FAIL ovf_release: got %0d frames left %h expected 1 frame 00000001", acc_l.size(), got(0, 0)); end
      n_checks++; if (valid16 !== 1'b0) begin n_errors++; $display("FAIL ovf_valid_drop: got %b expected 0", valid16); end
      send_frame(32'h0007, 32'h0008, 16, 1'b1, NB, 1);
      close_frame();
      n_checks++; if (got(0, 1) !== 32'h0007 || got(1, 1) !== 32'h0008) begin n_errors++; $display("FAIL ovf_next: got %h/%h expected 0007/0008", got(0, 1), got(1, 1)); end
      n_checks++; if (ovf16 !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf16); end
      @(posedge iCLK); #1 clr = 1'b1;
      @(posedge iCLK); #1 clr = 1'b0;
      @(negedge iCLK);
      n_checks++; if (ovf16 !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b expected 0", ovf16); end
   endtask

   task automatic test_truncated();
      rst_dut();
      lead_in(0, 4);
      send_frame(32'h1111, 32'h2222, 16, 1'b1, 10, 0);
      send_frame(32'hFFFF, 32'h0000, 16, 1'b1, NB, 0);
      close_frame();
      n_checks++; if (acc_l.size() !== 1) begin n_errors++; $display("FAIL trunc_count: got %0d expected 1", acc_l.size()); end
      n_checks++; if (got(0, 0) !== 32'hFFFF || got(1, 0) !== 32'h0000) begin n_errors++; $display("FAIL trunc_good: got %h/%h expected ffff/0000", got(0, 0), got(1, 0)); end
      n_checks++; if (ferr16 !== 1'b1) begin n_errors++; $display("FAIL trunc_ferr: got %b expected 1", ferr16); end
      n_checks++; if (ovf16 !== 1'b0) begin n_errors++; $display("FAIL trunc_ovf: got %b expected 0", ovf16); end
      @(posedge iCLK); #1 clr = 1'b1;
      @(posedge iCLK); #1 clr = 1'b0;
      @(negedge iCLK);
      n_checks++; if (ferr16 !== 1'b0) begin n_errors++; $display("FAIL trunc_clear: got %b expected 0", ferr16); end
   endtask

   task automatic test_lj24();
      rst_dut();
      lead_in(0, 4);
      send_frame(32'h800000, 32'h7FFFFF, 24, 1'b0, NB, 0);
      close_frame();
      n_checks++; if (lj_l.size() !== 1) begin n_errors++; $display("FAIL lj_count: got %0d expected 1", lj_l.size()); end
      n_checks++; if (got(2, 0) !== 32'h800000) begin n_errors++; $display("FAIL lj_left: got %h expected 00800000", got(2, 0)); end
      n_checks++; if (got(3, 0) !== 32'h7FFFFF) begin n_errors++; $display("FAIL lj_right: got %h expected 007fffff", got(3, 0)); end
      n_checks++; if ({ovf24, ferr24} !== 2'b00) begin n_errors++; $display("FAIL lj_flags: got %b expected 00", {ovf24, ferr24}); end
   endtask

   task automatic test_reset_mid();
      rst_dut();
      lead_in(0, 4);
      send_frame(32'h1357, 32'h2468, 16, 1'b1, NB, 0);
      fork
         send_frame(32'hDEAD, 32'hBEEF, 16, 1'b1, NB, 0);
         begin
            #(BCLK_HALF * 20);
            @(negedge iCLK);
            n_checks++; if (left16 !== 16'h1357) begin n_errors++; $display("FAIL rstmid_before: got %h expected 1357", left16); end
            @(posedge iCLK); #1 iRST = 1'b1;
            @(posedge iCLK); @(negedge iCLK);
            n_checks++; if ({valid16, left16, right16} !== 33'h0) begin n_errors++; $display("FAIL rstmid_zero: got %b/%h/%h expected 0/0000/0000", valid16, left16, right16); end
            #1 iRST = 1'b0;
         end
      join
      send_frame(32'h0F0F, 32'hF0F0, 16, 1'b1, NB, 0);
      close_frame();
      n_checks++; if (acc_l.size() !== 2) begin n_errors++; $display("FAIL rstmid_count: got %0d expected 2", acc_l.size()); end
      n_checks++; if (got(0, 1) !== 32'h0F0F || got(1, 1) !== 32'hF0F0) begin n_errors++; $display("FAIL rstmid_realign: got %h/%h expected 0f0f/f0f0", got(0, 1), got(1, 1)); end
      n_checks++; if ({ovf16, ferr16} !== 2'b00) begin n_errors++; $display("FAIL rstmid_flags: got %b expected 00", {ovf16, ferr16}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_mid_start();
      test_overflow();
      test_truncated();
      test_lj24();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
